conv_map_collector: RTL

//  Sink for the conv layer output stream. Accepts one signed accumulator per cycle

---
 rtl/conv_map_collector.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/conv_map_collector.sv
// Feature-map sink for the conv output stream: ReLU, Q-format rescale and saturate each
// accepted sample, then store it in raster order in a map_width x map_height RAM with a registered read port.
module conv_map_collector #(
  parameter int in_bits    = 32,
  parameter int out_bits   = 16,
  parameter int frac_shift = 12,
  parameter int map_width  = 24,
  parameter int map_height = 24,
  localparam int depth     = map_width * map_height,
  localparam int aw        = $clog2(depth),
  localparam int cw        = $clog2(depth + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic signed [in_bits-1:0]  conv_data,
  input  logic                       conv_invalid,
  input  logic                       conv_finish,
  input  logic                       rd_en,
  input  logic        [aw-1:0]       rd_addr,
  output logic        [out_bits-1:0] rd_data,
  output logic                       rd_valid,
  output logic                       busy,
  output logic                       map_done,
  output logic        [cw-1:0]       sample_count,
  output logic                       overflow_err,
  output logic                       short_err
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  localparam logic [cw-1:0]      depth_c   = cw'(depth);
  localparam logic [aw-1:0]      last_addr = aw'(depth - 1);
  localparam logic [in_bits-1:0] sat_lim   = in_bits'((2 ** out_bits) - 1);

  // Negative accumulators clamp to zero; anything above the output range saturates.
  function automatic logic [out_bits-1:0] scale_sat(input logic signed [in_bits-1:0] x);
    logic signed [in_bits-1:0] sh;
    sh = x >>> frac_shift;
    if (x[in_bits-1]) begin
      scale_sat = '0;
    end else if ($unsigned(sh) > sat_lim) begin
      scale_sat = '1;
    end else begin
      scale_sat = sh[out_bits-1:0];
    end
  endfunction

  logic [out_bits-1:0] mem [depth];

  state_t              state_q, state_d;
  logic [cw-1:0]       sample_count_q, sample_count_d;
  logic                map_done_q, map_done_d;
  logic                busy_q, busy_d;
  logic                overflow_err_q, overflow_err_d;
  logic                short_err_q, short_err_d;
  logic [out_bits-1:0] rd_data_q, rd_data_d;
  logic                rd_valid_q, rd_valid_d;
  logic                wr_en_s;
  logic [out_bits-1:0] wr_data_s;

  // Frame control: the sample count doubles as the raster write pointer.
  always_comb begin
    state_d        = state_q;
    sample_count_d = sample_count_q;
    map_done_d     = map_done_q;
    overflow_err_d = overflow_err_q;
    short_err_d    = short_err_q;
    wr_en_s        = 1'b0;
    wr_data_s      = scale_sat(conv_data);
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d        = ST_COLLECT;
          sample_count_d = '0;
          map_done_d     = 1'b0;
          overflow_err_d = 1'b0;
          short_err_d    = 1'b0;
        end else if (state_q == ST_DONE && !conv_invalid) begin
          overflow_err_d = 1'b1;
        end else begin
          state_d = state_q;
        end
      end
      ST_COLLECT: begin
        if (!conv_invalid) begin
          wr_en_s        = 1'b1;
          sample_count_d = sample_count_q + cw'(1);
        end else begin
          sample_count_d = sample_count_q;
        end
        // The short check deliberately looks at the count including this cycle's write.
        if (sample_count_d == depth_c) begin
          state_d    = ST_DONE;
          map_done_d = 1'b1;
        end else if (conv_finish) begin
          state_d     = ST_DONE;
          map_done_d  = 1'b1;
          short_err_d = 1'b1;
        end else begin
          state_d = ST_COLLECT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d == ST_COLLECT);
  end

  // Read path: out-of-range addresses return zero, idle cycles hold the last word.
  always_comb begin
    rd_valid_d = rd_en;
    if (!rd_en) begin
      rd_data_d = rd_data_q;
    end else if (rd_addr <= last_addr) begin
      rd_data_d = mem[rd_addr];
    end else begin
      rd_data_d = '0;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      sample_count_q <= '0;
      map_done_q     <= 1'b0;
      busy_q         <= 1'b0;
      overflow_err_q <= 1'b0;
      short_err_q    <= 1'b0;
      rd_data_q      <= '0;
      rd_valid_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      sample_count_q <= sample_count_d;
      map_done_q     <= map_done_d;
      busy_q         <= busy_d;
      overflow_err_q <= overflow_err_d;
      short_err_q    <= short_err_d;
      rd_data_q      <= rd_data_d;
      rd_valid_q     <= rd_valid_d;
    end
  end

  // Map storage survives reset so a partial frame stays readable.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[sample_count_q[aw-1:0]] <= wr_data_s;
    end
  end

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign busy         = busy_q;
  assign map_done     = map_done_q;
  assign sample_count = sample_count_q;
  assign overflow_err = overflow_err_q;
  assign short_err    = short_err_q;

endmodule
